// File: rtl/rv_pkg.sv
// Shared definitions for the rv_ ready/valid bus: beat type and FIFO sizing helper.
package rv_pkg;

  localparam int RV_WIDTH = 32;

  typedef logic [RV_WIDTH-1:0] rv_beat_t;

  // Occupancy counter must represent 0..depth inclusive, hence depth+1 values.
  function automatic int rv_fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rv_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module rv_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rv_fifo.sv
// Ready/valid elastic buffer: first-word-fall-through FIFO with registered valid and
// a ready that depends only on registered occupancy.
module rv_fifo
  import rv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int CNT_W = rv_fifo_cnt_w(DEPTH),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] t_dat,
  input  logic             t_valid,
  output logic             t_ready,
  output logic [WIDTH-1:0] i_dat,
  output logic             i_valid,
  input  logic             i_ready,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_next;
  logic             push;
  logic             pop;

  assign t_ready = !reset && (count_q != FULL);
  assign push    = t_valid && t_ready;
  assign pop     = i_valid && i_ready;
  assign count   = count_q;

  always_comb begin
    count_next = count_q;
    if (push && !pop) begin
      count_next = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_q - CNT_W'(1);
    end
  end

  // Pointers wrap modulo DEPTH on their own since DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      i_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count_q <= count_next;
      i_valid <= (count_next != '0);
    end
  end

  rv_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (t_dat),
    .raddr (rd_ptr),
    .rdata (i_dat)
  );

`ifndef SYNTHESIS
  a_count_range: assert property (@(posedge clock) disable iff (reset)
    count_q <= FULL);
  a_no_pop_empty: assert property (@(posedge clock) disable iff (reset)
    (i_valid && i_ready) |-> (count_q != '0));
  a_no_push_full: assert property (@(posedge clock) disable iff (reset)
    (t_valid && t_ready) |-> (count_q != FULL));
`endif

endmodule

// File: tb/tb_rv_fifo.sv
// Self-checking bench for rv_fifo: queue-based reference model, negedge monitor, directed and random traffic.
module tb_rv_fifo;
  import rv_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = rv_fifo_cnt_w(DEPTH);

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] t_dat;
  logic             t_valid;
  logic             t_ready;
  logic [WIDTH-1:0] i_dat;
  logic             i_valid;
  logic             i_ready;
  logic [CNT_W-1:0] count;

  rv_beat_t expQ[$];
  int       errors;
  int       checks;
  int       popTotal;
  bit       monEnable;

  rv_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .t_dat   (t_dat),
    .t_valid (t_valid),
    .t_ready (t_ready),
    .i_dat   (i_dat),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .count   (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, hold them across the next edge, return 1ns after it.
  task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] dat,
                               input logic ready);
    t_valid = valid;
    t_dat   = dat;
    i_ready = ready;
    @(posedge clock);
    #1;
  endtask

  // The model is a plain queue: a beat joins when offered and there is room, leaves
  // when the head is shown and the consumer is ready; reset empties it.
  always @(negedge clock) begin
    if (monEnable) begin
      checkOutput("count", 32'(count), 32'(expQ.size()));
      checkOutput("i_valid", 32'(i_valid), 32'(expQ.size() != 0));
      checkOutput("t_ready", 32'(t_ready), 32'(!reset && expQ.size() != DEPTH));
      if (expQ.size() != 0) begin
        checkOutput("i_dat", i_dat, expQ[0]);
      end
      if (reset) begin
        expQ.delete();
      end else begin
        automatic bit accept = t_valid && (expQ.size() < DEPTH);
        if (expQ.size() != 0 && i_ready) begin
          void'(expQ.pop_front());
          popTotal++;
        end
        if (accept) begin
          expQ.push_back(t_dat);
        end
      end
    end
  end

  initial begin
    int startPops;
    errors    = 0;
    checks    = 0;
    popTotal  = 0;
    monEnable = 1'b0;
    reset     = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    reset     = 1'b0;
    monEnable = 1'b1;
    #1;
    checkOutput("reset_count", 32'(count), 32'd0);
    checkOutput("reset_i_valid", 32'(i_valid), 32'd0);
    checkOutput("reset_t_ready", 32'(t_ready), 32'd1);

    // Fill to DEPTH with the consumer stalled, then offer a beat that must be refused.
    applyStimulus(1'b1, 32'h11, 1'b0);
    applyStimulus(1'b1, 32'h22, 1'b0);
    applyStimulus(1'b1, 32'h33, 1'b0);
    applyStimulus(1'b1, 32'h44, 1'b0);
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_t_ready", 32'(t_ready), 32'd0);
    checkOutput("full_head", i_dat, 32'h11);
    applyStimulus(1'b1, 32'h55, 1'b0);
    applyStimulus(1'b1, 32'h55, 1'b0);
    checkOutput("full_hold_count", 32'(count), 32'd4);
    checkOutput("full_hold_head", i_dat, 32'h11);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("drain_count", 32'(count), 32'd0);

    applyStimulus(1'b1, 32'hA5, 1'b0);
    checkOutput("single_i_valid", 32'(i_valid), 32'd1);
    checkOutput("single_i_dat", i_dat, 32'hA5);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("single_pop_count", 32'(count), 32'd0);
    checkOutput("single_pop_i_valid", 32'(i_valid), 32'd0);

    for (int k = 0; k < 100; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b1);
      checkOutput("stream_count", 32'(count), 32'd1);
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("stream_end_count", 32'(count), 32'd0);

    applyStimulus(1'b1, 32'h100, 1'b0);
    applyStimulus(1'b1, 32'h101, 1'b0);
    checkOutput("pp_pre_count", 32'(count), 32'd2);
    applyStimulus(1'b1, 32'h102, 1'b1);
    checkOutput("pp_count", 32'(count), 32'd2);
    checkOutput("pp_head", i_dat, 32'h101);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 32'h200 + 32'(k), 1'b1);
      checkOutput("wrap_count", 32'(count), 32'd2);
    end
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("wrap_drain_count", 32'(count), 32'd0);

    startPops = popTotal;
    for (int cyc = 0; cyc < 20000 && (popTotal - startPops) < 1000; cyc++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    checks++;
    if ((popTotal - startPops) < 1000) begin
      errors++;
      $display("[TB] FAIL random_beats: got %0d pops, expected 1000 within cycle budget",
               popTotal - startPops);
    end
    for (int k = 0; k < DEPTH + 2; k++) applyStimulus(1'b0, '0, 1'b1);
    checkOutput("random_drain_count", 32'(count), 32'd0);

    // Mid-operation reset with three beats held: all must vanish.
    applyStimulus(1'b1, 32'hC1, 1'b0);
    applyStimulus(1'b1, 32'hC2, 1'b0);
    applyStimulus(1'b1, 32'hC3, 1'b0);
    checkOutput("prereset_count", 32'(count), 32'd3);
    reset   = 1'b1;
    t_valid = 1'b1;
    t_dat   = 32'h77;
    i_ready = 1'b1;
    #1;
    checkOutput("inreset_t_ready", 32'(t_ready), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("postreset_i_valid", 32'(i_valid), 32'd0);
    checkOutput("postreset_count", 32'(count), 32'd0);
    checkOutput("postreset_t_ready", 32'(t_ready), 32'd1);
    applyStimulus(1'b1, 32'hEE, 1'b0);
    checkOutput("postreset_head", i_dat, 32'hEE);
    checkOutput("postreset_push_count", 32'(count), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("postreset_end_count", 32'(count), 32'd0);

    applyStimulus(1'b0, '0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
